// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and state encoding for the interrupt request latch
package irq_pkg;

    // Width of the downstream priority encoder input
    localparam int IRQ_N = 3;

    // Encoder codes returned with ack
    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_B0   = 2'b01;
    localparam logic [1:0] CODE_B1   = 2'b10;
    localparam logic [1:0] CODE_B2   = 2'b11;

    // Handshake FSM states
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } irq_state_e;

endpackage

// File: rtl/edge_det.sv
// rtl/edge_det.sv - W-wide rising-edge detector with synchronous reset
module edge_det #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sig_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] sig_q;

    // Previous-cycle copy; cleared to 0 so a line high right after reset reads as a rise
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/irq_request_latch.sv
// rtl/irq_request_latch.sv - pending-request latch feeding the priority encoder with valid/ack
module irq_request_latch
    import irq_pkg::*;
#(
    parameter int N           = IRQ_N,
    parameter bit EDGE        = 1'b1,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    input  logic [N-1:0] mask,
    input  logic         ack,
    input  logic [1:0]   ack_code,
    output logic [N-1:0] pend,
    output logic         valid,
    output logic [N-1:0] overflow,
    output logic         timeout
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    irq_state_e        state_q, state_d;
    logic [N-1:0]      pending_q, pending_d;
    logic [N-1:0]      overflow_q, overflow_d;
    logic [N-1:0]      pend_q, pend_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [N-1:0]      rise;
    logic [N-1:0]      set;
    logic [IRQ_N-1:0]  clr_full;
    logic [N-1:0]      clr;
    logic              ack_fire;

    edge_det #(.W(N)) u_edge_det (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (req_in),
        .rise_o (rise)
    );

    assign set      = EDGE ? rise : req_in;
    assign ack_fire = ack & (state_q == ST_PRESENT);

    // Decode the serviced code to a one-hot clear; ack outside PRESENT is ignored
    always_comb begin
        clr_full = '0;
        if (ack_fire) begin
            case (ack_code)
                CODE_NONE: clr_full    = '0;
                CODE_B0:   clr_full[0] = 1'b1;
                CODE_B1:   clr_full[1] = 1'b1;
                CODE_B2:   clr_full[2] = 1'b1;
            endcase
        end
    end

    assign clr = clr_full[N-1:0];

    // Pending and sticky overflow next state; a new set beats a same-cycle clear
    always_comb begin
        pending_d  = (pending_q & ~clr) | set;
        overflow_d = EDGE ? (overflow_q | (set & pending_q & ~clr)) : '0;
    end

    // Handshake FSM: load a masked snapshot in IDLE, hold it until ack or timeout
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (|(pending_q & ~mask)) begin
                    pend_d  = pending_q & ~mask;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    valid_d   = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // State registers; reset drops any in-flight snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            overflow_q <= '0;
            pend_q     <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pend     = pend_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
    assign timeout  = timeout_q;

endmodule
